// File: rtl/sfifo_pkt_if.sv
// sfifo_pkt_if: write/read handshake bundle for sfifo_pkt
interface sfifo_pkt_if #(
  parameter int BW = 8,
  parameter int LGFLEN = 4
);
  logic i_wr;
  logic [BW-1:0] i_data;
  logic i_last;
  logic i_abort;
  logic o_full;
  logic [LGFLEN:0] o_fill;
  logic i_rd;
  logic [BW-1:0] o_data;
  logic o_last;
  logic o_empty;
  logic [LGFLEN:0] o_avail;
  logic [LGFLEN:0] o_pkts;
  logic o_overflow;
  logic o_drop;
  logic o_afull;
  logic o_aempty;
  modport master (
    output i_wr, i_data, i_last, i_abort, i_rd,
    input o_full, o_fill, o_data, o_last, o_empty, o_avail, o_pkts,
    input o_overflow, o_drop, o_afull, o_aempty
  );
  modport slave (
    input i_wr, i_data, i_last, i_abort, i_rd,
    output o_full, o_fill, o_data, o_last, o_empty, o_avail, o_pkts,
    output o_overflow, o_drop, o_afull, o_aempty
  );
endinterface

// File: rtl/sfifo_pkt.sv
// sfifo_pkt: packet FIFO with commit/rollback of partial packets.
// Define SFIFO_PKT_ALMOST_EN to enable the o_afull/o_aempty thresholds.
module sfifo_pkt #(
  parameter int BW = 8,
  parameter int LGFLEN = 4,
  parameter int AFULL_THRESH = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input logic i_clk,
  input logic i_reset,
  sfifo_pkt_if.slave bus
);
  localparam int FLEN = 1 << LGFLEN;
  localparam int AW = LGFLEN + 1;
  if (AFULL_THRESH > FLEN || AEMPTY_THRESH > FLEN) begin : g_bad_thresh
    $error("sfifo_pkt: threshold exceeds depth");
  end
  logic [BW:0] mem [FLEN];
  logic [BW:0] head;
  logic [AW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, pkts_q, pkts_d;
  logic [AW-1:0] fill_d, avail_d;
  logic full_q, full_d, empty_q, empty_d, ovf_q, ovf_d, drop_q, drop_d;
  logic w_wr, w_rd, w_commit, w_pop_last, w_partial, w_ovf_end, w_rollback;
  assign head = mem[rd_q[LGFLEN-1:0]];
  always_comb begin
    w_partial = wr_q != cm_q;
    w_wr = bus.i_wr && !full_q && !ovf_q && !bus.i_abort;
    w_rd = bus.i_rd && !empty_q;
    w_commit = w_wr && bus.i_last;
    w_pop_last = w_rd && head[BW];
    w_ovf_end = ovf_q && bus.i_wr && bus.i_last && !bus.i_abort;
    w_rollback = bus.i_abort || w_ovf_end;
    wr_d = w_rollback ? cm_q : w_wr ? wr_q + AW'(1) : wr_q;
    cm_d = w_commit ? wr_q + AW'(1) : cm_q;
    rd_d = w_rd ? rd_q + AW'(1) : rd_q;
    pkts_d = pkts_q + AW'(w_commit) - AW'(w_pop_last);
    ovf_d = w_rollback ? 1'b0 : (ovf_q || (bus.i_wr && full_q && w_partial));
    drop_d = (bus.i_abort && (w_partial || ovf_q)) || w_ovf_end;
    fill_d = wr_d - rd_d;
    avail_d = cm_d - rd_d;
    full_d = fill_d == AW'(FLEN);
    empty_d = avail_d == '0;
  end
  always_ff @(posedge i_clk) begin
    if (w_wr) mem[wr_q[LGFLEN-1:0]] <= {bus.i_last, bus.i_data};
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
      pkts_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      cm_q <= cm_d;
      rd_q <= rd_d;
      pkts_q <= pkts_d;
      full_q <= full_d;
      empty_q <= empty_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  end
`ifdef SFIFO_PKT_ALMOST_EN
  logic afull_q, afull_d, aempty_q, aempty_d;
  always_comb begin
    afull_d = fill_d >= AW'(AFULL_THRESH);
    aempty_d = avail_d <= AW'(AEMPTY_THRESH);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      afull_q <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q <= afull_d;
      aempty_q <= aempty_d;
    end
  end
  assign bus.o_afull = afull_q;
  assign bus.o_aempty = aempty_q;
`else
  assign bus.o_afull = 1'b0;
  assign bus.o_aempty = 1'b0;
`endif
  assign bus.o_fill = wr_q - rd_q;
  assign bus.o_avail = cm_q - rd_q;
  assign bus.o_pkts = pkts_q;
  assign bus.o_full = full_q;
  assign bus.o_empty = empty_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_drop = drop_q;
  assign bus.o_data = head[BW-1:0];
  assign bus.o_last = head[BW];
endmodule

// File: tb/tb_sfifo_pkt.sv
// tb_sfifo_pkt: directed checks of commit, abort, overflow, wrap and thresholds
module tb_sfifo_pkt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
`ifdef SFIFO_PKT_ALMOST_EN
  localparam int ALM = 1;
`else
  localparam int ALM = 0;
`endif
  sfifo_pkt_if #(.BW(8), .LGFLEN(4)) bus ();
  sfifo_pkt #(.BW(8), .LGFLEN(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input int d, input bit l);
    bus.i_wr = 1'b1;
    bus.i_data = 8'(d);
    bus.i_last = l;
    tick();
    bus.i_wr = 1'b0;
    bus.i_last = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "timeout");
  end
  initial begin
    bus.i_wr = 1'b0;
    bus.i_data = '0;
    bus.i_last = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_rd = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_fill", bus.o_fill, 0);
    chk("rst_avail", bus.o_avail, 0);
    chk("rst_pkts", bus.o_pkts, 0);
    chk("rst_empty", bus.o_empty, 1);
    chk("rst_full", bus.o_full, 0);
    chk("rst_ovf", bus.o_overflow, 0);
    chk("rst_drop", bus.o_drop, 0);
    chk("rst_afull", bus.o_afull, 0);
    chk("rst_aempty", bus.o_aempty, ALM);
    wr(8'hA1, 0);
    chk("abc_empty1", bus.o_empty, 1);
    chk("abc_fill1", bus.o_fill, 1);
    wr(8'hB2, 0);
    chk("abc_empty2", bus.o_empty, 1);
    wr(8'hC3, 1);
    chk("abc_empty3", bus.o_empty, 0);
    chk("abc_avail", bus.o_avail, 3);
    chk("abc_pkts", bus.o_pkts, 1);
    chk("abc_d0", bus.o_data, 8'hA1);
    chk("abc_l0", bus.o_last, 0);
    bus.i_rd = 1'b1;
    tick();
    chk("abc_d1", bus.o_data, 8'hB2);
    chk("abc_l1", bus.o_last, 0);
    tick();
    chk("abc_d2", bus.o_data, 8'hC3);
    chk("abc_l2", bus.o_last, 1);
    chk("abc_pkts_mid", bus.o_pkts, 1);
    tick();
    chk("abc_empty_end", bus.o_empty, 1);
    chk("abc_pkts_end", bus.o_pkts, 0);
    tick();
    bus.i_rd = 1'b0;
    chk("rd_empty_avail", bus.o_avail, 0);
    chk("rd_empty_fill", bus.o_fill, 0);
    wr(8'hD0, 0);
    wr(8'hD1, 0);
    chk("ab_fill", bus.o_fill, 2);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("ab_drop", bus.o_drop, 1);
    chk("ab_fill0", bus.o_fill, 0);
    chk("ab_empty", bus.o_empty, 1);
    tick();
    chk("ab_drop_once", bus.o_drop, 0);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("ab_idle_nodrop", bus.o_drop, 0);
    wr(8'h5A, 1);
    chk("ab_next_avail", bus.o_avail, 1);
    chk("ab_next_data", bus.o_data, 8'h5A);
    chk("ab_next_last", bus.o_last, 1);
    bus.i_rd = 1'b1;
    tick();
    bus.i_rd = 1'b0;
    chk("ab_next_empty", bus.o_empty, 1);
    for (int i = 1; i <= 20; i++) begin
      wr(i, i == 20);
      if (i == 16) begin
        chk("of_full16", bus.o_full, 1);
        chk("of_fill16", bus.o_fill, 16);
        chk("of_ovf16", bus.o_overflow, 0);
      end
      if (i == 17) begin
        chk("of_ovf17", bus.o_overflow, 1);
        chk("of_fill17", bus.o_fill, 16);
      end
    end
    chk("of_drop", bus.o_drop, 1);
    chk("of_fill0", bus.o_fill, 0);
    chk("of_ovf0", bus.o_overflow, 0);
    chk("of_full0", bus.o_full, 0);
    chk("of_pkts", bus.o_pkts, 0);
    tick();
    chk("of_drop_once", bus.o_drop, 0);
    for (int k = 0; k < 16; k++) wr(8'h30 + k, k == 15);
    chk("cf_full", bus.o_full, 1);
    chk("cf_avail", bus.o_avail, 16);
    chk("cf_pkts", bus.o_pkts, 1);
    wr(8'hFF, 0);
    chk("cf_ign_ovf", bus.o_overflow, 0);
    chk("cf_ign_fill", bus.o_fill, 16);
    chk("cf_ign_drop", bus.o_drop, 0);
    chk("cf_d0", bus.o_data, 8'h30);
    bus.i_rd = 1'b1;
    tick();
    bus.i_rd = 1'b0;
    chk("cf_rd_fill", bus.o_fill, 15);
    chk("cf_rd_full", bus.o_full, 0);
    wr(8'hEE, 1);
    chk("cf_wr_fill", bus.o_fill, 16);
    chk("cf_wr_full", bus.o_full, 1);
    chk("cf_wr_pkts", bus.o_pkts, 2);
    bus.i_rd = 1'b1;
    for (int k = 1; k < 16; k++) begin
      chk("cf_drain_d", bus.o_data, 8'h30 + k);
      chk("cf_drain_l", bus.o_last, int'(k == 15));
      tick();
    end
    chk("cf_tail_d", bus.o_data, 8'hEE);
    chk("cf_tail_l", bus.o_last, 1);
    tick();
    bus.i_rd = 1'b0;
    chk("cf_empty", bus.o_empty, 1);
    chk("cf_pkts0", bus.o_pkts, 0);
    for (int k = 0; k < 13; k++) begin
      wr(k, k == 12);
      if (k == 10) chk("alm_afull11", bus.o_afull, 0);
      if (k == 11) chk("alm_afull12", bus.o_afull, ALM);
    end
    chk("alm_avail13", bus.o_avail, 13);
    chk("alm_aempty13", bus.o_aempty, 0);
    bus.i_rd = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("alm_avail3", bus.o_avail, 3);
    chk("alm_aempty3", bus.o_aempty, 0);
    chk("alm_afull3", bus.o_afull, 0);
    tick();
    chk("alm_avail2", bus.o_avail, 2);
    chk("alm_aempty2", bus.o_aempty, ALM);
    tick();
    tick();
    bus.i_rd = 1'b0;
    chk("alm_empty", bus.o_empty, 1);
    chk("alm_aempty0", bus.o_aempty, ALM);
    for (int k = 0; k < 100; k++) begin
      bus.i_wr = 1'b1;
      bus.i_last = 1'b1;
      bus.i_data = 8'(k);
      if (k > 0) begin
        chk("cc_data", bus.o_data, k - 1);
        chk("cc_empty", bus.o_empty, 0);
        chk("cc_pkts", bus.o_pkts, 1);
        chk("cc_full", bus.o_full, 0);
        bus.i_rd = 1'b1;
      end
      tick();
    end
    bus.i_wr = 1'b0;
    bus.i_last = 1'b0;
    chk("cc_tail_data", bus.o_data, 99);
    chk("cc_tail_avail", bus.o_avail, 1);
    tick();
    bus.i_rd = 1'b0;
    chk("cc_end_empty", bus.o_empty, 1);
    chk("cc_end_pkts", bus.o_pkts, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sfifo_pkt.md
Name: sfifo_pkt

Overview:
Synchronous packet FIFO for the switch datapath; successor to the plain word FIFO.
- Writer marks packet ends with i_last. Words become visible to the reader only once their packet is committed.
- Partial packets can be rolled back by an explicit abort or by overflow.
- Tracks word fill, committed-word fill and whole-packet count; each stored word carries its last flag.

Parameters:
BW, 8, data width in bits
LGFLEN, 4, log2 of depth; FLEN = 2^LGFLEN words
AFULL_THRESH, 12, o_afull asserts when o_fill >= this value (used only with macro)
AEMPTY_THRESH, 2, o_aempty asserts when o_avail <= this value (used only with macro)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_wr  in  1  write request
i_data  in  BW  write data
i_last  in  1  with i_wr: word is the final word of its packet; commits the packet
i_abort  in  1  discard the uncommitted partial packet
o_full  out  1  no free word
o_fill  out  LGFLEN+1  words stored, committed plus uncommitted
i_rd  in  1  read request
o_data  out  BW  head word, combinational from memory
o_last  out  1  last flag of head word
o_empty  out  1  no committed word available
o_avail  out  LGFLEN+1  committed words available to the reader
o_pkts  out  LGFLEN+1  complete packets in the FIFO
o_overflow  out  1  current packet has overflowed; sticky until that packet is dropped
o_drop  out  1  one-cycle pulse: a partial packet was discarded
o_afull  out  1  almost full
o_aempty  out  1  almost empty

Behaviour:
- Interface: reset i_reset, synchronous, active-high; clock i_clk.
- Pointers:
  - wr_addr, cm_addr (commit), rd_addr; each LGFLEN+1 bits, mod-2^(LGFLEN+1) arithmetic.
  - Memory is BW+1 bits wide and stores {last, data}, indexed by the low LGFLEN bits.
- Derived flags and counts:
  - o_fill = wr_addr - rd_addr; o_avail = cm_addr - rd_addr.
  - o_full = (o_fill == FLEN); o_empty = (o_avail == 0). Both registered or equivalent; no combinational path from i_rd or i_wr.
- Reset: all pointers 0, o_fill 0, o_avail 0, o_pkts 0, o_empty 1, o_full 0, o_overflow 0, o_drop 0, o_afull 0, o_aempty 1 if the macro is defined, else 0. A reset mid-packet discards everything.
- Accepted write: w_wr = i_wr && !o_full && !o_overflow && !i_abort.
  - Stores the word at wr_addr and increments wr_addr.
  - If i_last is also set, cm_addr takes the new wr_addr in the same clock edge and o_pkts increments.
  - Committed data is readable on the next cycle (1-cycle write-to-visible latency).
- Read: w_rd = i_rd && !o_empty.
  - Increments rd_addr. o_data and o_last always reflect mem[rd_addr].
  - If o_last is set, o_pkts decrements. A simultaneous commit and last-word read leave o_pkts unchanged.
  - i_rd while empty is ignored.
- Abort: i_abort sets wr_addr <= cm_addr and clears o_overflow.
  - o_drop pulses only if wr_addr != cm_addr or o_overflow was set.
  - Abort beats a same-cycle write, whose word is discarded. A same-cycle read proceeds normally.
- Overflow:
  - i_wr while o_full and wr_addr != cm_addr sets o_overflow.
  - While o_overflow is set, writes are ignored.
  - The next i_wr && i_last (or i_abort) rolls wr_addr back to cm_addr, clears o_overflow and pulses o_drop.
  - i_wr while full with no partial packet (wr_addr == cm_addr) is simply ignored; no flag is set.
  - A packet longer than FLEN therefore always drops; there is no deadlock.
- Simultaneous read and write: both proceed. Full or empty may not change.
- Wrap-around: pointers wrap naturally. Full/empty must stay correct across the 2^(LGFLEN+1) wrap.

Optional Feature:
SFIFO_PKT_ALMOST_EN
- Defined: o_afull = (o_fill >= AFULL_THRESH); o_aempty = (o_avail <= AEMPTY_THRESH). Both registered and updated with the counts, no extra lag.
- Undefined: o_afull and o_aempty are tied to 0 and the threshold logic is removed. Ports remain present.

Test Plan:
- LGFLEN=4: write 3-word packet A,B,C (last on C) -> o_empty stays 1 until the cycle after C; then o_avail=3, o_pkts=1; reads return A,B,C with o_last only on C, then o_empty=1, o_pkts=0.
- Write 2 words without last, then i_abort -> o_drop pulses once, o_fill=0, o_empty=1; the next packet's data is read unaffected.
- Write 20-word packet into a 16-deep FIFO -> o_full after word 16, o_overflow=1 at word 17; the write with last pulses o_drop, o_fill=0, o_overflow=0.
- Committed 16 words, then i_wr while full -> ignored, o_overflow=0; one read frees a slot, after which a write is accepted.
- Continuous concurrent one-word packet writes and reads for 100 cycles (wrapping pointers) -> data order preserved, o_pkts in 0..1, no spurious o_full/o_empty.
- Macro defined, AFULL_THRESH=12, AEMPTY_THRESH=2: fill 12 words -> o_afull=1; commit, then read down to 2 -> o_aempty=1. Macro undefined -> both remain 0.
